result_writeback_ctrl: RTL

//  Write-side counterpart of the memory-read controller: streams DEPTH result words from the

---
 rtl/result_writeback_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/result_writeback_ctrl.sv
// ============================================================================
// result_writeback_ctrl
//
// Purpose:
//   Streams DEPTH result words from the multiplier datapath into the result
//   memory at consecutive addresses starting at BASE_ADDR. The address wraps
//   modulo 2**ADDR_W. When the run is complete the block raises done.
//   It uses the same start/done handshake as the memory-read controller:
//   a start level moves IDLE->WRITE, and done holds in FINISH until start is
//   seen again, which returns the block to IDLE.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   start      in   1       level; IDLE->WRITE, FINISH->IDLE
//   in_valid   in   1       datapath offers a result word
//   in_data    in   DATA_W  result word
//   in_ready   out  1       block accepts a word this cycle (high in WRITE)
//   mem_we     out  1       memory write enable, one pulse per accepted word
//   mem_addr   out  ADDR_W  memory write address (holds when mem_we=0)
//   mem_wdata  out  DATA_W  memory write data (holds when mem_we=0)
//   busy       out  1       high in WRITE
//   done       out  1       high in FINISH
//   checksum   out  DATA_W  sum mod 2**DATA_W of accepted words
//                           (present only when WB_CHECKSUM_EN is defined)
//
// Configuration:
//   WB_CHECKSUM_EN  - when defined, adds the checksum port and its adder.
//                     When undefined, the port and adder are absent and all
//                     other behaviour is identical.
// ============================================================================
module result_writeback_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
`ifdef WB_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               last_word;
    logic [ADDR_W-1:0]  addr_next;

    // in_ready is a registered copy of (state == WRITE), so gating with it is
    // the same as gating with the state itself.
    assign accept    = in_valid && in_ready;
    assign last_word = (count == CNT_W'(DEPTH - 1));

    // count < DEPTH <= 2**ADDR_W, so truncating count to ADDR_W loses nothing;
    // the ADDR_W-bit add gives the modulo-2**ADDR_W wrap for free.
    assign addr_next = ADDR_W'(BASE_ADDR) + ADDR_W'(count);

`ifdef WB_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign checksum = sum;
`endif

    // Single FSM block. The Moore flags (in_ready, busy, done) are registered
    // from the next state so that they always match the current state. The
    // write port is loaded one cycle after an accept, and mem_we drops back
    // to zero by default, which makes it a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef WB_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
`ifdef WB_CHECKSUM_EN
                    sum   <= '0;
`endif
                    if (start) begin
                        state    <= WRITE;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_next;
                        mem_wdata <= in_data;
                        count     <= count + CNT_W'(1);
`ifdef WB_CHECKSUM_EN
                        sum       <= sum + in_data;
`endif
                        if (last_word) begin
                            state    <= FINISH;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    // The checksum stays frozen here and clears on the way
                    // back to IDLE, so it reads zero in the first IDLE cycle.
                    if (start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        count <= '0;
`ifdef WB_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
